// File: rtl/module_kb_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out 8 data bits,
// odd parity and stop on device clock edges, then sample the device acknowledge.
module module_kb_tx #(
  parameter int INHIBIT_CYCLES    = 12000,
  parameter int DATA_SETUP_CYCLES = 500,
  parameter int TIMEOUT_CYCLES    = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       kb_clk_in,
  input  logic       kb_data_in,
  output logic       kb_clk_oe,
  output logic       kb_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  localparam int DLY_MAX = (INHIBIT_CYCLES > DATA_SETUP_CYCLES) ? INHIBIT_CYCLES : DATA_SETUP_CYCLES;
  localparam int DW      = $clog2(DLY_MAX + 1);
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] INH_LAST = DW'(INHIBIT_CYCLES - 1);
  localparam logic [DW-1:0] SET_LAST = DW'(DATA_SETUP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_SETUP, S_SEND, S_ACK, S_WAIT, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [3:0]    bcnt, bcnt_n;
  logic [7:0]    data_q, data_n;
  logic          par_q, par_n;
  logic          err_q, err_n;
  logic          clk_oe_n, data_oe_n, busy_n, done_n, ack_err_n;
  logic          clk_s1, clk_s2, clk_prev, data_s1, data_s2;
  logic          fall;

  // Line idle level is 1, so the synchronizers reset high to avoid a false edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= kb_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= kb_data_in;
      data_s2  <= data_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      dcnt       <= '0;
      tcnt       <= '0;
      bcnt       <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      err_q      <= 1'b0;
      kb_clk_oe  <= 1'b0;
      kb_data_oe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ack_err    <= 1'b0;
    end else begin
      state      <= state_n;
      dcnt       <= dcnt_n;
      tcnt       <= tcnt_n;
      bcnt       <= bcnt_n;
      data_q     <= data_n;
      par_q      <= par_n;
      err_q      <= err_n;
      kb_clk_oe  <= clk_oe_n;
      kb_data_oe <= data_oe_n;
      busy       <= busy_n;
      done       <= done_n;
      ack_err    <= ack_err_n;
    end
  end

  always_comb begin
    state_n   = state;
    dcnt_n    = dcnt;
    tcnt_n    = tcnt;
    bcnt_n    = bcnt;
    data_n    = data_q;
    par_n     = par_q;
    err_n     = err_q;
    clk_oe_n  = kb_clk_oe;
    data_oe_n = kb_data_oe;
    busy_n    = busy;
    done_n    = 1'b0;
    ack_err_n = 1'b0;
    case (state)
      S_IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        busy_n    = 1'b0;
        if (tx_start) begin
          data_n   = tx_data;
          par_n    = ~^tx_data;
          err_n    = 1'b0;
          busy_n   = 1'b1;
          clk_oe_n = 1'b1;
          dcnt_n   = '0;
          state_n  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (dcnt == INH_LAST) begin
          dcnt_n    = '0;
          data_oe_n = 1'b1;
          state_n   = S_SETUP;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      S_SETUP: begin
        if (dcnt == SET_LAST) begin
          dcnt_n   = '0;
          clk_oe_n = 1'b0;
          bcnt_n   = '0;
          tcnt_n   = '0;
          state_n  = S_SEND;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      S_SEND, S_ACK, S_WAIT: begin
        if (tcnt == TO_LAST) begin
          // Device stalled: free both lines and report failure.
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          err_n     = 1'b1;
          busy_n    = 1'b0;
          done_n    = 1'b1;
          ack_err_n = 1'b1;
          state_n   = S_DONE;
        end else begin
          tcnt_n = tcnt + 1'b1;
          if (state == S_SEND) begin
            if (fall) begin
              bcnt_n = bcnt + 1'b1;
              if (bcnt < 4'd8) begin
                data_oe_n = ~data_q[bcnt[2:0]];
              end else if (bcnt == 4'd8) begin
                data_oe_n = ~par_q;
              end else begin
                data_oe_n = 1'b0;
                state_n   = S_ACK;
              end
            end
          end else if (state == S_ACK) begin
            if (fall) begin
              err_n   = data_s2;
              state_n = S_WAIT;
            end
          end else if (clk_s2 && data_s2) begin
            busy_n    = 1'b0;
            done_n    = 1'b1;
            ack_err_n = err_q;
            state_n   = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
